// File: rtl/level_accel_seq.sv
// -----------------------------------------------------------------------------
// level_accel_seq
//   Command sequencer for the byte-level I2C master that talks to the
//   bubble-level accelerometer. After reset it writes CFG_VAL to CFG_REG
//   (sensor active mode). It then reads X_H, X_L, Y_H, Y_L in a burst every
//   SAMPLE_PERIOD clocks and publishes signed 16-bit X/Y samples.
//   Any NACK on a written byte aborts the transaction with a STOP, raises the
//   sticky error flag and forces a full reconfiguration.
//
//   Optional feature macro: LEVEL_SEQ_RETRY_EN
//     When defined, a NACKed transaction is retried immediately, up to
//     MAX_RETRY times, before the error path is taken.
//
// Ports
//   clk            in   system clock
//   reset_i        in   synchronous, active-high reset
//   cmd_valid_o    out  command to the I2C master is valid
//   cmd_ready_i    in   I2C master accepts the command
//   cmd_op_o       out  0 START, 1 RESTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP
//   cmd_data_o     out  byte for WRITE, 0 for every other op
//   rsp_valid_i    in   one-cycle pulse: the accepted command completed
//   rsp_data_i     in   byte read (READ_* responses)
//   rsp_nack_i     in   slave NACKed (WRITE responses only)
//   sample_x_o     out  signed X sample {X_H, X_L}
//   sample_y_o     out  signed Y sample {Y_H, Y_L}
//   sample_valid_o out  one-cycle pulse: new X/Y pair
//   error_o        out  sticky bus-error flag, cleared by the next good sample
// -----------------------------------------------------------------------------
module level_accel_seq #(
  parameter logic [6:0]  DEV_ADDR      = 7'h1D,
  parameter logic [7:0]  CFG_REG       = 8'h2A,
  parameter logic [7:0]  CFG_VAL       = 8'h01,
  parameter logic [7:0]  DATA_REG      = 8'h01,
  parameter logic [23:0] SAMPLE_PERIOD = 24'd500000,
  parameter int          MAX_RETRY     = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [2:0]  cmd_op_o,
  output logic [7:0]  cmd_data_o,
  input  logic        rsp_valid_i,
  input  logic [7:0]  rsp_data_i,
  input  logic        rsp_nack_i,
  output logic [15:0] sample_x_o,
  output logic [15:0] sample_y_o,
  output logic        sample_valid_o,
  output logic        error_o
);

  typedef enum logic [3:0] {
    S_CFG_START, S_CFG_ADDR, S_CFG_REG, S_CFG_VAL, S_CFG_STOP,
    S_WAIT,
    S_RD_START, S_RD_ADDRW, S_RD_REG, S_RD_RESTART, S_RD_ADDRR,
    S_RD_BYTE, S_RD_STOP,
    S_ERR_STOP
  } state_e;

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_RESTART   = 3'd1;
  localparam logic [2:0] OP_WRITE     = 3'd2;
  localparam logic [2:0] OP_READ_ACK  = 3'd3;
  localparam logic [2:0] OP_READ_NACK = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;

  localparam int          RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [23:0] WAIT_LOAD = SAMPLE_PERIOD - 24'd1;
`ifdef LEVEL_SEQ_RETRY_EN
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);
`endif

  // busy_q is the CMD_WAIT sub-phase: command accepted, response pending.
  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                need_cfg_q, need_cfg_d;   // next WAIT exit goes to config
  logic                txn_cfg_q, txn_cfg_d;     // current transaction is the config write
  logic [3:0][7:0]     hold_q, hold_d;           // [0]=X_H [1]=X_L [2]=Y_H [3]=Y_L
  logic                cmd_valid_q, cmd_valid_d;
  logic [2:0]          cmd_op_q, cmd_op_d;
  logic [7:0]          cmd_data_q, cmd_data_d;
  logic [15:0]         sample_x_q, sample_x_d;
  logic [15:0]         sample_y_q, sample_y_d;
  logic                sample_valid_q, sample_valid_d;
  logic                error_q, error_d;

  logic                burst_ok;   // read burst STOP completed cleanly
  logic                err_set;    // abort STOP completed, error path taken
  logic                retry_ok;

  function automatic logic is_write(input state_e s);
    return (s == S_CFG_ADDR) || (s == S_CFG_REG) || (s == S_CFG_VAL) ||
           (s == S_RD_ADDRW) || (s == S_RD_REG)  || (s == S_RD_ADDRR);
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q        <= S_CFG_START;
      busy_q         <= 1'b0;
      idx_q          <= 2'd0;
      cnt_q          <= 24'd0;
      retry_q        <= '0;
      need_cfg_q     <= 1'b0;
      txn_cfg_q      <= 1'b1;
      hold_q         <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_op_q       <= 3'd0;
      cmd_data_q     <= 8'h00;
      sample_x_q     <= 16'h0000;
      sample_y_q     <= 16'h0000;
      sample_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      need_cfg_q     <= need_cfg_d;
      txn_cfg_q      <= txn_cfg_d;
      hold_q         <= hold_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_op_q       <= cmd_op_d;
      cmd_data_q     <= cmd_data_d;
      sample_x_q     <= sample_x_d;
      sample_y_q     <= sample_y_d;
      sample_valid_q <= sample_valid_d;
      error_q        <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    need_cfg_d = need_cfg_q;
    txn_cfg_d  = txn_cfg_q;
    hold_d     = hold_q;
    burst_ok   = 1'b0;
    err_set    = 1'b0;
    retry_ok   = 1'b0;
`ifdef LEVEL_SEQ_RETRY_EN
    retry_ok   = (retry_q < MAX_R);
`endif

    if (state_q == S_WAIT) begin
      if (cnt_q == 24'd0) state_d = need_cfg_q ? S_CFG_START : S_RD_START;
      else                cnt_d   = cnt_q - 24'd1;
    end else if (!busy_q) begin
      // Key off the registered valid: it trails the state by one cycle
      // right after reset.
      if (cmd_valid_q && cmd_ready_i) busy_d = 1'b1;
    end else if (rsp_valid_i) begin
      busy_d = 1'b0;
      if (rsp_nack_i && is_write(state_q)) begin
        state_d = S_ERR_STOP;
      end else begin
        case (state_q)
          S_CFG_START:  state_d = S_CFG_ADDR;
          S_CFG_ADDR:   state_d = S_CFG_REG;
          S_CFG_REG:    state_d = S_CFG_VAL;
          S_CFG_VAL:    state_d = S_CFG_STOP;
          S_CFG_STOP: begin
            state_d    = S_WAIT;
            cnt_d      = WAIT_LOAD;
            need_cfg_d = 1'b0;
            retry_d    = '0;
          end
          S_RD_START:   state_d = S_RD_ADDRW;
          S_RD_ADDRW:   state_d = S_RD_REG;
          S_RD_REG:     state_d = S_RD_RESTART;
          S_RD_RESTART: state_d = S_RD_ADDRR;
          S_RD_ADDRR: begin
            state_d = S_RD_BYTE;
            idx_d   = 2'd0;
          end
          S_RD_BYTE: begin
            hold_d[idx_q] = rsp_data_i;
            if (idx_q == 2'd3) state_d = S_RD_STOP;
            else               idx_d   = idx_q + 2'd1;
          end
          S_RD_STOP: begin
            state_d  = S_WAIT;
            cnt_d    = WAIT_LOAD;
            retry_d  = '0;
            burst_ok = 1'b1;
          end
          S_ERR_STOP: begin
            if (retry_ok) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = txn_cfg_q ? S_CFG_START : S_RD_START;
            end else begin
              // A fresh reconfiguration gets a full retry budget again.
              state_d    = S_WAIT;
              cnt_d      = WAIT_LOAD;
              need_cfg_d = 1'b1;
              retry_d    = '0;
              err_set    = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    if (state_d == S_CFG_START)     txn_cfg_d = 1'b1;
    else if (state_d == S_RD_START) txn_cfg_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Output logic: command and sample outputs are registered, computed from
  // the state being entered so they line up with state_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_valid_d    = 1'b0;
    cmd_op_d       = OP_START;
    cmd_data_d     = 8'h00;
    sample_x_d     = sample_x_q;
    sample_y_d     = sample_y_q;
    sample_valid_d = 1'b0;
    error_d        = error_q;

    if (state_d != S_WAIT && !busy_d) begin
      cmd_valid_d = 1'b1;
      case (state_d)
        S_CFG_START, S_RD_START: cmd_op_d = OP_START;
        S_RD_RESTART:            cmd_op_d = OP_RESTART;
        S_CFG_ADDR, S_RD_ADDRW: begin
          cmd_op_d   = OP_WRITE;
          cmd_data_d = {DEV_ADDR, 1'b0};
        end
        S_RD_ADDRR: begin
          cmd_op_d   = OP_WRITE;
          cmd_data_d = {DEV_ADDR, 1'b1};
        end
        S_CFG_REG: begin
          cmd_op_d   = OP_WRITE;
          cmd_data_d = CFG_REG;
        end
        S_CFG_VAL: begin
          cmd_op_d   = OP_WRITE;
          cmd_data_d = CFG_VAL;
        end
        S_RD_REG: begin
          cmd_op_d   = OP_WRITE;
          cmd_data_d = DATA_REG;
        end
        S_RD_BYTE: cmd_op_d = (idx_d == 2'd3) ? OP_READ_NACK : OP_READ_ACK;
        S_CFG_STOP, S_RD_STOP, S_ERR_STOP: cmd_op_d = OP_STOP;
        default: cmd_valid_d = 1'b0;
      endcase
    end

    // Samples only move on a clean burst, so partial bytes never leak out.
    if (burst_ok) begin
      sample_x_d     = {hold_q[0], hold_q[1]};
      sample_y_d     = {hold_q[2], hold_q[3]};
      sample_valid_d = 1'b1;
      error_d        = 1'b0;
    end
    if (err_set) error_d = 1'b1;
  end

  assign cmd_valid_o    = cmd_valid_q;
  assign cmd_op_o       = cmd_op_q;
  assign cmd_data_o     = cmd_data_q;
  assign sample_x_o     = sample_x_q;
  assign sample_y_o     = sample_y_q;
  assign sample_valid_o = sample_valid_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_level_accel_seq.sv
// Directed bench for level_accel_seq with a small I2C master model.
module tb_level_accel_seq;
  localparam logic [23:0] P = 24'd20;

  localparam logic [10:0] C_START = 11'h000, C_RESTART = 11'h100, C_W3A = 11'h23A,
                          C_W3B = 11'h23B, C_W2A = 11'h22A, C_W01 = 11'h201,
                          C_RACK = 11'h300, C_RNACK = 11'h400, C_STOP = 11'h500;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid_o, cmd_ready_i = 1'b0;
  logic [2:0]  cmd_op_o;
  logic [7:0]  cmd_data_o;
  logic        rsp_valid_i = 1'b0, rsp_nack_i = 1'b0;
  logic [7:0]  rsp_data_i = 8'h00;
  logic [15:0] sample_x_o, sample_y_o;
  logic        sample_valid_o, error_o;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  level_accel_seq #(.SAMPLE_PERIOD(P)) dut (
    .clk(clk), .reset_i(reset_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_op_o(cmd_op_o), .cmd_data_o(cmd_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_nack_i(rsp_nack_i),
    .sample_x_o(sample_x_o), .sample_y_o(sample_y_o),
    .sample_valid_o(sample_valid_o), .error_o(error_o)
  );

  // I2C master model: logs accepted commands, answers two cycles later.
  logic [2:0] log_op[$];
  logic [7:0] log_data[$];
  logic [7:0] rd_q[$];
  logic [7:0] nack_byte = 8'h3B;
  int  nack_left = 0;
  bit  nack_reads = 0, spur_req = 0;
  bit  pend = 0, prev_valid = 0, prev_sv = 0;
  int  rsp_cnt = 0, cyc = 0, sv_count = 0, sv_cyc = 0, vstart_cyc = 0, sv_long = 0;
  logic [7:0] pend_data = 8'h00;
  logic       pend_nack = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rsp_valid_i = 1'b0; rsp_nack_i = 1'b0; rsp_data_i = 8'h00;
      if (reset_i) begin
        pend = 0;
      end else if (pend) begin
        if (rsp_cnt == 0) begin
          rsp_valid_i = 1'b1; rsp_data_i = pend_data; rsp_nack_i = pend_nack; pend = 0;
        end else rsp_cnt--;
      end else if (spur_req) begin
        rsp_valid_i = 1'b1; rsp_nack_i = 1'b1; rsp_data_i = 8'hEE; spur_req = 0;
      end
      if (sample_valid_o) begin sv_count++; sv_cyc = cyc; if (prev_sv) sv_long++; end
      prev_sv = sample_valid_o;
      if (cmd_valid_o && !prev_valid && cmd_op_o == 3'd0) vstart_cyc = cyc;
      prev_valid = cmd_valid_o;
      if (!reset_i && cmd_valid_o && cmd_ready_i) begin
        log_op.push_back(cmd_op_o); log_data.push_back(cmd_data_o);
        pend = 1; rsp_cnt = 1; pend_nack = 1'b0; pend_data = 8'h00;
        if (cmd_op_o == 3'd2 && cmd_data_o == nack_byte && nack_left > 0) begin
          pend_nack = 1'b1; nack_left--;
        end
        if (cmd_op_o == 3'd3 || cmd_op_o == 3'd4) begin
          pend_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
          pend_nack = nack_reads;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_log(input int n, input int budget);
    int t = 0;
    while (log_op.size() < n && t < budget) begin step(); t++; end
    n_chk++;
    if (log_op.size() < n) begin
      n_fail++; $display("FAIL wait_log: got %0d commands, need %0d", log_op.size(), n);
    end
  endtask

  task automatic wait_sv(input int budget);
    int t = 0; bit seen = 0;
    while (!seen && t < budget) begin step(); t++; seen = sample_valid_o; end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL wait_sv: no sample_valid_o in %0d cycles", budget); end
  endtask

  task automatic wait_err(input int budget);
    int t = 0; bit seen = 0;
    while (!seen && t < budget) begin step(); t++; seen = error_o; end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL wait_err: no error_o in %0d cycles", budget); end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; cmd_ready_i = 1'b0;
    repeat (3) step();
    n_chk++;
    if ({cmd_valid_o, cmd_op_o, cmd_data_o} !== 12'h000) begin
      n_fail++; $display("FAIL reset_cmd: got %h want 000", {cmd_valid_o, cmd_op_o, cmd_data_o});
    end
    n_chk++;
    if ({sample_x_o, sample_y_o} !== 32'h0) begin
      n_fail++; $display("FAIL reset_samples: got %h want 0", {sample_x_o, sample_y_o});
    end
    n_chk++;
    if ({sample_valid_o, error_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00", {sample_valid_o, error_o});
    end
  endtask

  task automatic test_config();
    logic [10:0] exp [5];
    exp = '{C_START, C_W3A, C_W2A, C_W01, C_STOP};
    reset_i = 1'b0; cmd_ready_i = 1'b1;
    wait_log(5, 100);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({log_op[i], log_data[i]} !== exp[i]) begin
        n_fail++; $display("FAIL cfg_cmd[%0d]: got %h want %h", i, {log_op[i], log_data[i]}, exp[i]);
      end
    end
    n_chk++;
    if (sv_count !== 0 || error_o !== 1'b0) begin
      n_fail++; $display("FAIL cfg_flags: got sv=%0d err=%b want 0/0", sv_count, error_o);
    end
  endtask

  task automatic test_read_burst();
    logic [10:0] exp [10];
    int base;
    exp = '{C_START, C_W3A, C_W01, C_RESTART, C_W3B, C_RACK, C_RACK, C_RACK, C_RNACK, C_STOP};
    base = log_op.size();
    rd_q.push_back(8'h12); rd_q.push_back(8'h34); rd_q.push_back(8'hFE); rd_q.push_back(8'hDC);
    wait_sv(300);
    n_chk++;
    if (sample_x_o !== 16'h1234 || sample_y_o !== 16'hFEDC) begin
      n_fail++; $display("FAIL burst1_sample: got %h/%h want 1234/fedc", sample_x_o, sample_y_o);
    end
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if ({log_op[base+i], log_data[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL rd_cmd[%0d]: got %h want %h", i, {log_op[base+i], log_data[base+i]}, exp[i]);
      end
    end
    step();
    cmd_ready_i = 1'b0;   // hold off the next burst's START for the stall test
    n_chk++;
    if (sample_valid_o !== 1'b0 || sample_x_o !== 16'h1234) begin
      n_fail++; $display("FAIL sv_pulse: got sv=%b x=%h want 0/1234", sample_valid_o, sample_x_o);
    end
    begin
      int t = 0;
      while (!cmd_valid_o && t < 100) begin step(); t++; end
    end
    step();
    n_chk++;
    if (vstart_cyc - sv_cyc !== 20) begin
      n_fail++; $display("FAIL period: got %0d want 20", vstart_cyc - sv_cyc);
    end
  endtask

  task automatic test_stall();
    int base, stable;
    base = log_op.size(); stable = 0;
    nack_reads = 1;
    rd_q.push_back(8'h80); rd_q.push_back(8'h00); rd_q.push_back(8'h7F); rd_q.push_back(8'hFF);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) spur_req = 1;
      step();
      if (cmd_valid_o === 1'b1 && cmd_op_o === 3'd0 && cmd_data_o === 8'h00) stable++;
    end
    n_chk++;
    if (stable !== 7 || log_op.size() !== base) begin
      n_fail++; $display("FAIL stall_hold: got %0d stable, %0d accepted want 7/0", stable, log_op.size() - base);
    end
    cmd_ready_i = 1'b1;
    wait_sv(300);
    nack_reads = 0;
    n_chk++;
    if (log_op.size() !== base + 10 || {log_op[base], log_data[base]} !== C_START ||
        {log_op[base+1], log_data[base+1]} !== C_W3A) begin
      n_fail++; $display("FAIL stall_seq: got %0d cmds first %h %h want 10 000 23a",
                         log_op.size() - base, {log_op[base], log_data[base]}, {log_op[base+1], log_data[base+1]});
    end
    n_chk++;
    if (sample_x_o !== 16'h8000 || sample_y_o !== 16'h7FFF || error_o !== 1'b0) begin
      n_fail++; $display("FAIL burst2_sample: got %h/%h err=%b want 8000/7fff 0", sample_x_o, sample_y_o, error_o);
    end
    n_chk++;
    if (sv_long !== 0) begin
      n_fail++; $display("FAIL sv_width: got %0d long pulses want 0", sv_long);
    end
  endtask

  task automatic test_nack();
    logic [10:0] exp [11];
    int base;
    exp = '{C_START, C_W3A, C_W01, C_RESTART, C_W3B, C_STOP, C_START, C_W3A, C_W2A, C_W01, C_STOP};
    base = log_op.size();
    nack_left = 1;
    wait_err(300);
    n_chk++;
    if (sample_x_o !== 16'h8000 || sample_y_o !== 16'h7FFF || sv_count !== 2) begin
      n_fail++; $display("FAIL nack_keep: got %h/%h sv=%0d want 8000/7fff 2", sample_x_o, sample_y_o, sv_count);
    end
    n_chk++;
    if (log_op.size() !== base + 6) begin
      n_fail++; $display("FAIL nack_len: got %0d want 6", log_op.size() - base);
    end
    wait_log(base + 11, 200);
    for (int i = 0; i < 11; i++) begin
      n_chk++;
      if ({log_op[base+i], log_data[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL nack_cmd[%0d]: got %h want %h", i, {log_op[base+i], log_data[base+i]}, exp[i]);
      end
    end
    n_chk++;
    if (error_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", error_o); end
    rd_q.push_back(8'h01); rd_q.push_back(8'h02); rd_q.push_back(8'h03); rd_q.push_back(8'h04);
    wait_sv(300);
    n_chk++;
    if (sample_x_o !== 16'h0102 || sample_y_o !== 16'h0304 || error_o !== 1'b0) begin
      n_fail++; $display("FAIL recover: got %h/%h err=%b want 0102/0304 0", sample_x_o, sample_y_o, error_o);
    end
  endtask

  task automatic test_retry();
    int base, n3b, nstop;
    base = log_op.size();
    nack_left = 2;
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33); rd_q.push_back(8'h44);
    wait_sv(500);
    n3b = 0; nstop = 0;
    for (int i = base; i < log_op.size(); i++) begin
      if ({log_op[i], log_data[i]} == C_W3B) n3b++;
      if ({log_op[i], log_data[i]} == C_STOP) nstop++;
    end
    n_chk++;
    if (n3b !== 3 || nstop !== 3) begin
      n_fail++; $display("FAIL retry_count: got %0d 3B / %0d STOP want 3/3", n3b, nstop);
    end
    n_chk++;
    if (sample_x_o !== 16'h1122 || sample_y_o !== 16'h3344 || error_o !== 1'b0) begin
      n_fail++; $display("FAIL retry_sample: got %h/%h err=%b want 1122/3344 0", sample_x_o, sample_y_o, error_o);
    end
    base = log_op.size();
    nack_left = 3;
    wait_err(500);
    n3b = 0;
    for (int i = base; i < log_op.size(); i++) if ({log_op[i], log_data[i]} == C_W3B) n3b++;
    n_chk++;
    if (n3b !== 3 || sample_x_o !== 16'h1122) begin
      n_fail++; $display("FAIL retry_exhaust: got %0d 3B x=%h want 3/1122", n3b, sample_x_o);
    end
    rd_q.push_back(8'h55); rd_q.push_back(8'h66); rd_q.push_back(8'h77); rd_q.push_back(8'h88);
    wait_sv(500);
    n_chk++;
    if (sample_x_o !== 16'h5566 || sample_y_o !== 16'h7788 || error_o !== 1'b0) begin
      n_fail++; $display("FAIL retry_recover: got %h/%h err=%b want 5566/7788 0", sample_x_o, sample_y_o, error_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp [5];
    int base;
    exp = '{C_START, C_W3A, C_W2A, C_W01, C_STOP};
    base = log_op.size();
    rd_q.push_back(8'hAA); rd_q.push_back(8'hBB); rd_q.push_back(8'hCC); rd_q.push_back(8'hDD);
    wait_log(base + 8, 300);   // third read (byte index 2) just accepted
    reset_i = 1'b1;
    step();
    n_chk++;
    if ({cmd_valid_o, cmd_op_o, cmd_data_o, sample_x_o, sample_y_o, sample_valid_o, error_o} !== 46'h0) begin
      n_fail++; $display("FAIL mid_reset: got v=%b op=%h d=%h x=%h y=%h sv=%b e=%b want all 0",
                         cmd_valid_o, cmd_op_o, cmd_data_o, sample_x_o, sample_y_o, sample_valid_o, error_o);
    end
    rd_q.delete();
    reset_i = 1'b0;
    base = log_op.size();
    wait_log(base + 5, 100);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({log_op[base+i], log_data[base+i]} !== exp[i]) begin
        n_fail++; $display("FAIL reconfig_cmd[%0d]: got %h want %h", i, {log_op[base+i], log_data[base+i]}, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_read_burst();
    test_stall();
`ifdef LEVEL_SEQ_RETRY_EN
    test_retry();
`else
    test_nack();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
